// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared state encoding and sizing helpers for the reset sequencer
package reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    localparam int LOSS_COUNT_W = 8;

    // Counter width for a bound n: $clog2(n), never below one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchronizer, synchronous active-high reset to 0
module sync_2ff (
    input  logic clk_in,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - qualifies PLL lock and releases domain resets in staggered order
// Optional lock-wait watchdog built when RESET_SEQ_WATCHDOG_EN is defined.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP          = 16,
    parameter int NUM_STAGES         = 3,
    parameter int LOSS_FILTER        = 4,
    parameter int WDOG_CYCLES        = 2700000
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic                    pll_locked_async,
    output logic [NUM_STAGES-1:0]   rst_out,
    output logic                    ready,
    output logic                    lock_loss_pulse,
    output logic [LOSS_COUNT_W-1:0] lock_loss_count,
    output logic                    lock_timeout
);

    localparam int STAB_W = cnt_w(LOCK_STABLE_CYCLES);
    localparam int GAP_W  = cnt_w(STAGE_GAP);
    localparam int STG_W  = cnt_w(NUM_STAGES);
    localparam int LOSS_W = cnt_w(LOSS_FILTER);

    logic lock_s;

    sync_2ff u_lock_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .d      (pll_locked_async),
        .q      (lock_s)
    );

    seq_state_t              state_q, state_d;
    logic [STAB_W-1:0]       stab_q, stab_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic [STG_W-1:0]        stage_q, stage_d;
    logic [LOSS_W-1:0]       loss_q, loss_d;
    logic [NUM_STAGES-1:0]   rst_out_q, rst_out_d;
    logic                    ready_q, ready_d;
    logic                    pulse_q, pulse_d;
    logic [LOSS_COUNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= WAIT_LOCK;
            stab_q    <= '0;
            gap_q     <= '0;
            stage_q   <= '0;
            loss_q    <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            pulse_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            stab_q    <= stab_d;
            gap_q     <= gap_d;
            stage_q   <= stage_d;
            loss_q    <= loss_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            pulse_q   <= pulse_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        stab_d    = stab_q;
        gap_d     = gap_q;
        stage_d   = stage_q;
        loss_d    = loss_q;
        rst_out_d = rst_out_q;
        ready_d   = ready_q;
        pulse_d   = 1'b0;
        count_d   = count_q;

        case (state_q)
            WAIT_LOCK: begin
                rst_out_d = '1;
                ready_d   = 1'b0;
                stab_d    = '0;
                loss_d    = '0;
                if (lock_s) begin
                    state_d = STABILIZE;
                end
            end
            STABILIZE: begin
                // Unfiltered: a single low sample restarts qualification.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (stab_q == STAB_W'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d = RELEASE;
                    gap_d   = '0;
                    stage_d = '0;
                    loss_d  = '0;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            RELEASE, RUN: begin
                if (!lock_s && (loss_q == LOSS_W'(LOSS_FILTER - 1))) begin
                    state_d   = WAIT_LOCK;
                    rst_out_d = '1;
                    ready_d   = 1'b0;
                    pulse_d   = 1'b1;
                    loss_d    = '0;
                    if (count_q != '1) begin
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    loss_d = lock_s ? '0 : loss_q + 1'b1;
                    if (state_q == RELEASE) begin
                        if (gap_q == GAP_W'(STAGE_GAP - 1)) begin
                            gap_d = '0;
                            for (int k = 0; k < NUM_STAGES; k++) begin
                                if (stage_q == STG_W'(k)) begin
                                    rst_out_d[k] = 1'b0;
                                end
                            end
                            if (stage_q == STG_W'(NUM_STAGES - 1)) begin
                                state_d = RUN;
                                ready_d = 1'b1;
                            end else begin
                                stage_d = stage_q + 1'b1;
                            end
                        end else begin
                            gap_d = gap_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
    end

    assign rst_out         = rst_out_q;
    assign ready           = ready_q;
    assign lock_loss_pulse = pulse_q;
    assign lock_loss_count = count_q;

`ifdef RESET_SEQ_WATCHDOG_EN
    localparam int WDOG_W = cnt_w(WDOG_CYCLES);

    logic [WDOG_W-1:0] wdog_q;
    logic              timeout_q;

    // Counter holds at its bound so the flag stays set until rst.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else if (state_q == WAIT_LOCK) begin
            if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
                timeout_q <= 1'b1;
            end else begin
                wdog_q <= wdog_q + 1'b1;
            end
        end else begin
            wdog_q <= '0;
        end
    end

    assign lock_timeout = timeout_q;
`else
    // Constant 0; WDOG_CYCLES is referenced only so both builds share one interface.
    assign lock_timeout = (WDOG_CYCLES < 0);
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - self-checking bench for reset_sequencer (segment table plus scoreboard)
module tb_reset_sequencer;

`ifdef RESET_SEQ_WATCHDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       lock;
    logic [2:0] rst_out;
    logic       ready;
    logic       pulse;
    logic [7:0] count;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    reset_sequencer #(
        .LOCK_STABLE_CYCLES (8),
        .STAGE_GAP          (4),
        .NUM_STAGES         (3),
        .LOSS_FILTER        (4),
        .WDOG_CYCLES        (50)
    ) dut (
        .clk_in           (clk),
        .rst              (rst),
        .pll_locked_async (lock),
        .rst_out          (rst_out),
        .ready            (ready),
        .lock_loss_pulse  (pulse),
        .lock_loss_count  (count),
        .lock_timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ro;
        logic       rdy;
        logic       pls;
        logic [7:0] cnt;
        logic       to;
    } exp_t;

    // n edges of constant inputs over which the outputs must hold the listed values
    typedef struct {
        int   n;
        logic r;
        logic l;
        exp_t e;
    } seg_t;

    exp_t sb[$];
    seg_t tbl_main[$];
    seg_t tbl_wdog[$];

    function automatic seg_t mk(int n, logic r, logic l, logic [2:0] ro, logic rdy,
                                logic pls, logic [7:0] cnt, logic to);
        seg_t s;
        s.n = n; s.r = r; s.l = l;
        s.e.ro = ro; s.e.rdy = rdy; s.e.pls = pls; s.e.cnt = cnt; s.e.to = to;
        return s;
    endfunction

    function automatic logic [7:0] sat(int v);
        return (v > 255) ? 8'd255 : 8'(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic l, input exp_t e);
        exp_t x;
        @(negedge clk);
        rst  = r;
        lock = l;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            x = sb.pop_front();
            check("rst_out", 32'(rst_out), 32'(x.ro));
            check("ready", 32'(ready), 32'(x.rdy));
            check("lock_loss_pulse", 32'(pulse), 32'(x.pls));
            check("lock_loss_count", 32'(count), 32'(x.cnt));
            check("lock_timeout", 32'(timeout), 32'(x.to));
        end
    endtask

    task automatic run_segs(input seg_t t[$]);
        foreach (t[i]) begin
            for (int j = 0; j < t[i].n; j++) begin
                step(t[i].r, t[i].l, t[i].e);
            end
        end
    endtask

    initial begin
        exp_t e;
        rst  = 1'b1;
        lock = 1'b0;

        // Reset, then lock held: release at edges 15/19/23
        tbl_main.push_back(mk( 2, 1, 0, 3'b111, 0, 0, 0, 0));
        tbl_main.push_back(mk(14, 0, 1, 3'b111, 0, 0, 0, 0));
        tbl_main.push_back(mk( 4, 0, 1, 3'b110, 0, 0, 0, 0));
        tbl_main.push_back(mk( 4, 0, 1, 3'b100, 0, 0, 0, 0));
        tbl_main.push_back(mk( 5, 0, 1, 3'b000, 1, 0, 0, 0));
        // RUN: 3 low cycles filtered out, then 4 low cycles is a loss
        tbl_main.push_back(mk( 3, 0, 0, 3'b000, 1, 0, 0, 0));
        tbl_main.push_back(mk( 5, 0, 1, 3'b000, 1, 0, 0, 0));
        tbl_main.push_back(mk( 4, 0, 0, 3'b000, 1, 0, 0, 0));
        tbl_main.push_back(mk( 1, 0, 1, 3'b000, 1, 0, 0, 0));
        tbl_main.push_back(mk( 1, 0, 1, 3'b111, 0, 1, 1, 0));
        tbl_main.push_back(mk(12, 0, 1, 3'b111, 0, 0, 1, 0));
        tbl_main.push_back(mk( 4, 0, 1, 3'b110, 0, 0, 1, 0));
        tbl_main.push_back(mk( 2, 0, 1, 3'b100, 0, 0, 1, 0));
        // rst during the resequence clears the counter as well
        tbl_main.push_back(mk( 1, 1, 1, 3'b111, 0, 0, 0, 0));
        tbl_main.push_back(mk(14, 0, 1, 3'b111, 0, 0, 0, 0));
        tbl_main.push_back(mk( 4, 0, 1, 3'b110, 0, 0, 0, 0));
        tbl_main.push_back(mk( 4, 0, 1, 3'b100, 0, 0, 0, 0));
        tbl_main.push_back(mk( 2, 0, 1, 3'b000, 1, 0, 0, 0));
        // One-cycle glitch in STABILIZE: requalify, no loss counted
        tbl_main.push_back(mk( 2, 1, 1, 3'b111, 0, 0, 0, 0));
        tbl_main.push_back(mk( 4, 0, 1, 3'b111, 0, 0, 0, 0));
        tbl_main.push_back(mk( 1, 0, 0, 3'b111, 0, 0, 0, 0));
        tbl_main.push_back(mk(14, 0, 1, 3'b111, 0, 0, 0, 0));
        tbl_main.push_back(mk( 4, 0, 1, 3'b110, 0, 0, 0, 0));
        tbl_main.push_back(mk( 4, 0, 1, 3'b100, 0, 0, 0, 0));
        tbl_main.push_back(mk( 2, 0, 1, 3'b000, 1, 0, 0, 0));
        // rst at edge 17 with lock held
        tbl_main.push_back(mk( 2, 1, 1, 3'b111, 0, 0, 0, 0));
        tbl_main.push_back(mk(14, 0, 1, 3'b111, 0, 0, 0, 0));
        tbl_main.push_back(mk( 2, 0, 1, 3'b110, 0, 0, 0, 0));
        tbl_main.push_back(mk( 1, 1, 1, 3'b111, 0, 0, 0, 0));
        tbl_main.push_back(mk(14, 0, 1, 3'b111, 0, 0, 0, 0));
        tbl_main.push_back(mk( 4, 0, 1, 3'b110, 0, 0, 0, 0));
        tbl_main.push_back(mk( 4, 0, 1, 3'b100, 0, 0, 0, 0));
        tbl_main.push_back(mk( 2, 0, 1, 3'b000, 1, 0, 0, 0));

        // Lock held low: watchdog fires after 50 WAIT_LOCK cycles and stays set through RUN
        tbl_wdog.push_back(mk( 2, 1, 0, 3'b111, 0, 0, 0, 0));
        tbl_wdog.push_back(mk(49, 0, 0, 3'b111, 0, 0, 0, 0));
        tbl_wdog.push_back(mk( 1, 0, 0, 3'b111, 0, 0, 0, WDOG_ON));
        tbl_wdog.push_back(mk(14, 0, 1, 3'b111, 0, 0, 0, WDOG_ON));
        tbl_wdog.push_back(mk( 4, 0, 1, 3'b110, 0, 0, 0, WDOG_ON));
        tbl_wdog.push_back(mk( 4, 0, 1, 3'b100, 0, 0, 0, WDOG_ON));
        tbl_wdog.push_back(mk( 2, 0, 1, 3'b000, 1, 0, 0, WDOG_ON));

        run_segs(tbl_main);

        // 260 loss events in RELEASE: counter saturates at 255, pulse fires every time
        e.rdy = 1'b0; e.pls = 1'b0; e.cnt = 8'd0; e.to = 1'b0; e.ro = 3'b111;
        step(1'b1, 1'b1, e);
        step(1'b1, 1'b1, e);
        step(1'b0, 1'b1, e);
        step(1'b0, 1'b1, e);
        for (int i = 0; i < 260; i++) begin
            for (int k = 0; k < 19; k++) begin
                e.ro  = (k < 12) ? 3'b111 : (k < 16) ? 3'b110 : (k < 18) ? 3'b100 : 3'b111;
                e.pls = (k == 18);
                e.cnt = (k == 18) ? sat(i + 1) : sat(i);
                step(1'b0, (k < 13 || k > 16), e);
            end
        end

        run_segs(tbl_wdog);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
